// File: rtl/clause_cell.sv
// Clause evaluator: stores up to NUM_LITS literals and classifies the clause as
// satisfied, unit, conflicting or open against a registered variable snapshot.
module clause_cell #(
  parameter int NUM_LITS = 4,
  parameter int IDX_W    = $clog2(NUM_LITS),
  parameter int CNT_W    = $clog2(NUM_LITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [1:0]            wr_pol_i,
  input  logic                  eval_i,
  input  logic [2*NUM_LITS-1:0] var_value_i,
  input  logic                  imp_ack_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  clausesat_o,
  output logic [CNT_W-1:0]      freelitcnt_o,
  output logic                  imp_valid_o,
  output logic [IDX_W-1:0]      imp_idx_o,
  output logic [1:0]            imp_value_o,
  output logic                  conflict_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVAL  = 2'd1;
  localparam logic [1:0] IMPLY = 2'd2;
  localparam logic [1:0] CONFL = 2'd3;

  logic [1:0]                state;
  logic [NUM_LITS-1:0][1:0]  pol;
  logic [2*NUM_LITS-1:0]     vars;
  logic                      sat;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          imp_idx;
  logic [1:0]                imp_value;

  logic                      any_true;
  logic                      any_present;
  logic [CNT_W-1:0]          free_cnt;
  logic [IDX_W-1:0]          free_idx;
  logic [1:0]                free_pol;

  // A present literal is true exactly when its assigned value equals its polarity code.
  always_comb begin
    any_true    = 1'b0;
    any_present = 1'b0;
    free_cnt    = '0;
    free_idx    = '0;
    free_pol    = '0;
    for (int unsigned i = 0; i < unsigned'(NUM_LITS); i++) begin
      if (pol[i] == 2'b01 || pol[i] == 2'b10) begin
        any_present = 1'b1;
        if (vars[2*i +: 2] == 2'b00 || vars[2*i +: 2] == 2'b11) begin
          free_cnt = free_cnt + CNT_W'(1);
          free_idx = IDX_W'(i);
          free_pol = pol[i];
        end else if (vars[2*i +: 2] == pol[i]) begin
          any_true = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pol       <= '0;
      vars      <= '0;
      sat       <= 1'b0;
      cnt       <= '0;
      imp_idx   <= '0;
      imp_value <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      sat   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_i) begin
            for (int unsigned i = 0; i < unsigned'(NUM_LITS); i++) begin
              if (wr_idx_i == IDX_W'(i)) pol[i] <= wr_pol_i;
            end
          end
          if (eval_i) begin
            vars  <= var_value_i;
            state <= EVAL;
          end
        end
        EVAL: begin
          sat <= any_true;
          cnt <= free_cnt;
          if (any_true || !any_present) begin
            state <= IDLE;
          end else if (free_cnt == '0) begin
            state <= CONFL;
          end else if (free_cnt == CNT_W'(1)) begin
            state     <= IMPLY;
            imp_idx   <= free_idx;
            imp_value <= free_pol;
          end else begin
            state <= IDLE;
          end
        end
        IMPLY: begin
          if (imp_ack_i) state <= IDLE;
        end
        CONFL: begin
          state <= CONFL;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign imp_valid_o  = (state == IMPLY);
  assign conflict_o   = (state == CONFL);
  assign clausesat_o  = sat;
  assign freelitcnt_o = cnt;
  assign imp_idx_o    = imp_idx;
  assign imp_value_o  = imp_value;

endmodule

// File: tb/tb_clause_cell.sv
// Bench for clause_cell: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural clause model.
module tb_clause_cell;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_i = 1'b0;
  logic [1:0] wr_idx_i = '0;
  logic [1:0] wr_pol_i = '0;
  logic       eval_i = 1'b0;
  logic [7:0] var_value_i = '0;
  logic       imp_ack_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       busy_o, clausesat_o, imp_valid_o, conflict_o;
  logic [2:0] freelitcnt_o;
  logic [1:0] imp_idx_o, imp_value_o;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  clause_cell #(.NUM_LITS(N)) dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .wr_idx_i(wr_idx_i), .wr_pol_i(wr_pol_i),
    .eval_i(eval_i), .var_value_i(var_value_i), .imp_ack_i(imp_ack_i), .clear_i(clear_i),
    .busy_o(busy_o), .clausesat_o(clausesat_o), .freelitcnt_o(freelitcnt_o),
    .imp_valid_o(imp_valid_o), .imp_idx_o(imp_idx_o), .imp_value_o(imp_value_o),
    .conflict_o(conflict_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: clause contents, a pending-evaluation flag, and the held result.
  logic [1:0] m_pol [N];
  logic [7:0] m_vars;
  bit         m_pending, m_imp, m_conf, m_sat;
  int         m_cnt, m_idx;
  logic [1:0] m_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_pol[i] = 2'b00;
      m_vars = '0; m_pending = 0; m_imp = 0; m_conf = 0; m_sat = 0;
      m_cnt = 0; m_idx = 0; m_val = 2'b00;
    end else if (clear_i) begin
      m_pending = 0; m_imp = 0; m_conf = 0; m_sat = 0; m_cnt = 0;
    end else if (m_pending) begin
      int n_true, n_present, n_free, f_idx;
      n_true = 0; n_present = 0; n_free = 0; f_idx = 0;
      for (int i = 0; i < N; i++) begin
        logic [1:0] p, v;
        p = m_pol[i];
        v = m_vars[2*i +: 2];
        if (p == 2'b01 || p == 2'b10) begin
          n_present++;
          if (v == 2'b01 || v == 2'b10) begin
            if (v == p) n_true++;
          end else begin
            n_free++;
            f_idx = i;
          end
        end
      end
      m_pending = 0;
      m_sat = (n_true > 0);
      m_cnt = n_free;
      if (n_true == 0 && n_present > 0) begin
        if (n_free == 0) m_conf = 1;
        else if (n_free == 1) begin
          m_imp = 1;
          m_idx = f_idx;
          m_val = m_pol[f_idx];
        end
      end
    end else if (m_imp) begin
      if (imp_ack_i) m_imp = 0;
    end else if (!m_conf) begin
      if (wr_i && int'(wr_idx_i) < N) m_pol[wr_idx_i] = wr_pol_i;
      if (eval_i) begin
        m_vars = var_value_i;
        m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("busy", busy_o, m_pending || m_imp || m_conf);
      chk("sat", clausesat_o, m_sat);
      chk("cnt", freelitcnt_o, m_cnt);
      chk("imp_valid", imp_valid_o, m_imp);
      chk("conflict", conflict_o, m_conf);
      if (m_imp) begin
        chk("imp_idx", imp_idx_o, m_idx);
        chk("imp_value", imp_value_o, m_val);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [1:0] p);
    wr_i = 1; wr_idx_i = idx; wr_pol_i = p;
    cyc();
    wr_i = 0;
  endtask

  task automatic do_eval(input logic [7:0] v);
    eval_i = 1; var_value_i = v;
    cyc();
    eval_i = 0;
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_sat"}, clausesat_o, 0);
    chk({tag, "_cnt"}, freelitcnt_o, 0);
    chk({tag, "_imp_valid"}, imp_valid_o, 0);
    chk({tag, "_conflict"}, conflict_o, 0);
  endtask

  initial begin
    #1 rst = 1;
    cyc(); cyc();
    chk_all_zero("rst");
    chk("rst_imp_idx", imp_idx_o, 0);
    chk("rst_imp_value", imp_value_o, 0);
    rst = 0; run = 1;
    cyc();

    // Three positive literals, all unassigned.
    wr(0, 2'b10); wr(1, 2'b10); wr(2, 2'b10);
    do_eval(8'h00);
    chk("t1_cnt", freelitcnt_o, 3);
    chk("t1_sat", clausesat_o, 0);
    chk("t1_imp", imp_valid_o, 0);
    chk("t1_conf", conflict_o, 0);
    chk("t1_busy", busy_o, 0);

    // Unit clause on slot 2; a write during IMPLY must be dropped.
    do_eval(8'h05);
    chk("t2_valid", imp_valid_o, 1);
    chk("t2_idx", imp_idx_o, 2);
    chk("t2_value", imp_value_o, 2'b10);
    chk("t2_busy", busy_o, 1);
    wr(0, 2'b01);
    repeat (4) begin
      cyc();
      chk("t2_hold_valid", imp_valid_o, 1);
      chk("t2_hold_idx", imp_idx_o, 2);
      chk("t2_hold_value", imp_value_o, 2'b10);
    end
    imp_ack_i = 1;
    cyc();
    imp_ack_i = 0;
    chk("t2_ack_valid", imp_valid_o, 0);
    chk("t2_ack_busy", busy_o, 0);

    imp_ack_i = 1;
    do_eval(8'h05);
    chk("t2b_valid", imp_valid_o, 1);
    chk("t2b_sat", clausesat_o, 0);
    chk("t2b_idx", imp_idx_o, 2);
    cyc();
    imp_ack_i = 0;
    chk("t2b_min_len", imp_valid_o, 0);

    // Conflict, held until clear; evals while in CONFL are ignored.
    wr(2, 2'b01);
    do_eval(8'h65);
    chk("t3_conf", conflict_o, 1);
    chk("t3_cnt", freelitcnt_o, 0);
    chk("t3_busy", busy_o, 1);
    eval_i = 1; var_value_i = 8'h00;
    cyc(); cyc();
    eval_i = 0;
    chk("t3_hold_conf", conflict_o, 1);
    clear_i = 1;
    cyc();
    clear_i = 0;
    chk("t3_clr_conf", conflict_o, 0);
    chk("t3_clr_busy", busy_o, 0);

    // Satisfied clause.
    do_eval(8'h08);
    chk("t4_sat", clausesat_o, 1);
    chk("t4_cnt", freelitcnt_o, 2);
    chk("t4_imp", imp_valid_o, 0);

    // Write and eval in the same cycle: new literal is counted.
    wr_i = 1; wr_idx_i = 2'd3; wr_pol_i = 2'b10; eval_i = 1; var_value_i = 8'h00;
    cyc();
    wr_i = 0; eval_i = 0;
    cyc();
    chk("t5_cnt", freelitcnt_o, 4);
    chk("t5_sat", clausesat_o, 0);

    // Clear wins over ack.
    do_eval(8'h25);
    chk("t6_valid", imp_valid_o, 1);
    chk("t6_idx", imp_idx_o, 3);
    chk("t6_value", imp_value_o, 2'b10);
    clear_i = 1; imp_ack_i = 1;
    cyc();
    clear_i = 0; imp_ack_i = 0;
    chk_all_zero("t6_clr");

    // Asynchronous reset during IMPLY wipes storage.
    do_eval(8'h25);
    chk("t7_valid", imp_valid_o, 1);
    #1 rst = 1;
    #1;
    chk_all_zero("t7_rst");
    cyc();
    rst = 0;
    cyc();
    do_eval(8'($urandom));
    chk_all_zero("t7_empty");
    wr(1, 2'b11);
    do_eval(8'($urandom));
    chk_all_zero("t7_pol11");

    for (int n = 0; n < 3000; n++) begin
      wr_i        = ($urandom_range(0, 1) == 0);
      wr_idx_i    = 2'($urandom);
      wr_pol_i    = 2'($urandom);
      eval_i      = ($urandom_range(0, 2) == 0);
      var_value_i = 8'($urandom);
      imp_ack_i   = ($urandom_range(0, 2) == 0);
      clear_i     = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 0; wr_i = 0; eval_i = 0; imp_ack_i = 0; clear_i = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
